// File: rtl/wb_master_seq.sv
// Wishbone classic-cycle initiator.
// It accepts one command (direction, word-aligned base address, beat count).
// It then runs that many single-word bus cycles at consecutive word addresses.
// Write data comes from a valid/ready stream. Read data leaves on a valid/ready stream.
//
// Handshake rule for cmd, wr and rd: a transfer happens on the rising clock
// edge where valid and ready are both high. A source that raises valid holds
// valid and data stable until that edge. Ready never depends on valid.
module wb_master_seq #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             done,
  output logic             err
);

  // Wide enough to hold TIMEOUT-1, which is the last count before an abort.
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    BUS   = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_d;
  logic             we_q;
  logic [31:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_q;
  logic [LEN_W-1:0] beat_nxt;
  logic [TO_W-1:0]  to_cnt;
  logic [31:0]      dat_o_q;
  logic [31:0]      rd_data_q;
  logic             cyc_q;
  logic             err_q;
  logic             last_beat;

  // Per-cycle events decoded by the FSM and consumed by the datapath.
  logic accept, fetch_hs, ack_hit, timeout_hit, rd_hs;

  assign beat_nxt  = beat_q + LEN_W'(1);
  assign last_beat = (beat_nxt == len_q);

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_d;
  end

  // Next-state decode. Ack is only looked at while strobing, so a stray ack is ignored.
  always_comb begin
    state_d     = state;
    accept      = 1'b0;
    fetch_hs    = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    rd_hs       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_len == '0)  state_d = DONE;
          else if (cmd_we)    state_d = FETCH;
          else                state_d = BUS;
        end
      end
      FETCH: begin
        if (wr_valid) begin
          fetch_hs = 1'b1;
          state_d  = BUS;
        end
      end
      BUS: begin
        // An ack on the final timeout cycle still wins over the abort.
        if (wbm_ack_i) begin
          ack_hit = 1'b1;
          if (!we_q)          state_d = HOLD;
          else if (last_beat) state_d = DONE;
          else                state_d = FETCH;
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      HOLD: begin
        if (rd_ready) begin
          rd_hs   = 1'b1;
          state_d = last_beat ? DONE : BUS;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, beat counter, data registers, timeout counter and cycle framing.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      we_q      <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      to_cnt    <= '0;
      dat_o_q   <= '0;
      rd_data_q <= '0;
      cyc_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        we_q   <= cmd_we;
        base_q <= cmd_adr & 32'hFFFF_FFFC;
        len_q  <= cmd_len;
        beat_q <= '0;
      end else if ((ack_hit && we_q) || rd_hs) begin
        beat_q <= beat_nxt;
      end
      if (fetch_hs)          dat_o_q   <= wr_data;
      if (ack_hit && !we_q)  rd_data_q <= wbm_dat_i;
      // Staying in BUS means no ack and no abort on this cycle.
      // Every other case restarts the count.
      to_cnt <= (state == BUS && state_d == BUS) ? to_cnt + TO_W'(1) : '0;
      // cyc opens on the first strobe. It stays open across the FETCH/HOLD gaps between beats.
      cyc_q  <= (state_d == BUS) || (cyc_q && (state_d == FETCH || state_d == HOLD));
      err_q  <= timeout_hit;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == FETCH);
  assign rd_valid  = (state == HOLD);
  assign rd_data   = rd_data_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = (state == BUS);
  assign wbm_we_o  = cyc_q & we_q;
  assign wbm_sel_o = wbm_stb_o ? 4'hF : 4'h0;
  // The word offset is zero-extended to 32 bits so that the address wraps naturally.
  assign wbm_adr_o = base_q + (32'(beat_q) << 2);
  assign wbm_dat_o = dat_o_q;
  assign done      = (state == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed bench for wb_master_seq (TIMEOUT=4).
// It contains a negedge bus/stream responder, monitors, and hand-computed expectations.
module tb_wb_master_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        cmd_valid, cmd_we;
  logic [31:0] cmd_adr;
  logic [7:0]  cmd_len;
  logic        cmd_ready;
  logic [31:0] wr_data   = 32'h0;
  logic        wr_valid  = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready  = 1'b0;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_ack_i = 1'b0;
  logic        done, err;

  wb_master_seq #(.LEN_W(8), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .done(done), .err(err)
  );

  // ---------------- stimulus config (written by the main sequence only) ----------------
  logic [31:0] wr_src [0:15];
  int          wr_n = 0;
  logic [31:0] rd_src [0:15];
  int          rs_n = 0;
  bit          ack_en = 1'b0;
  int          ack_delay = 2;
  int          stall_at = 0;
  int          stall_cfg = 0;

  // ---------------- responder / monitor state (written by the negedge block only) ----------------
  int          wr_idx = 0, rs_idx = 0, s_cnt = 0, stall_run = 0;
  bit          hs_pend = 1'b0;
  logic [31:0] log_adr [0:63];
  logic [31:0] log_dat [0:63];
  logic [3:0]  log_sel [0:63];
  logic        log_we  [0:63];
  int          log_n = 0;
  logic [31:0] rd_log [0:63];
  int          rd_log_n = 0;
  int done_cnt = 0, err_cnt = 0, stb_cyc = 0, stb_rise = 0, cyc_cyc = 0, cyc_rise = 0;
  int wrr_cyc = 0, rdv_cyc = 0, stb_in_hold = 0, busy_ready = 0, err_bad = 0, rd_unstable = 0;
  bit p_stb = 1'b0, p_cyc = 1'b0, p_rdv = 1'b0, p_hs = 1'b0;
  logic [31:0] p_rdata = 32'h0;

  // Slave, write-stream source, read-stream sink and event counters, all mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (wbm_stb_o) stb_cyc++;
    if (wbm_stb_o && !p_stb) stb_rise++;
    if (wbm_cyc_o) cyc_cyc++;
    if (wbm_cyc_o && !p_cyc) cyc_rise++;
    if (wr_ready) wrr_cyc++;
    if (rd_valid) rdv_cyc++;
    if (wbm_stb_o && rd_valid) stb_in_hold++;
    if (wbm_cyc_o && cmd_ready) busy_ready++;
    if (err && (wbm_cyc_o || wbm_stb_o)) err_bad++;
    if (rd_valid && p_rdv && !p_hs && rd_data !== p_rdata) rd_unstable++;
    p_stb = wbm_stb_o;
    p_cyc = wbm_cyc_o;
    if (!rst_n) begin
      wbm_ack_i = 1'b0;
      s_cnt     = 0;
      hs_pend   = 1'b0;
      rd_ready  = 1'b0;
      p_rdv     = 1'b0;
      p_hs      = 1'b0;
    end else begin
      // slave: ack asserted during the ack_delay-th strobe cycle, held for one cycle
      if (wbm_ack_i) begin
        wbm_ack_i = 1'b0;
        s_cnt     = 0;
      end else if (wbm_cyc_o && wbm_stb_o) begin
        if (ack_en && s_cnt == ack_delay - 1) begin
          wbm_ack_i      = 1'b1;
          log_adr[log_n] = wbm_adr_o;
          log_dat[log_n] = wbm_dat_o;
          log_sel[log_n] = wbm_sel_o;
          log_we[log_n]  = wbm_we_o;
          log_n++;
          if (!wbm_we_o) begin
            wbm_dat_i = (rs_idx < rs_n) ? rd_src[rs_idx] : 32'hDEAD_BEEF;
            rs_idx++;
          end
        end else begin
          s_cnt++;
        end
      end else begin
        s_cnt = 0;
      end
      // write stream source
      if (hs_pend) wr_idx++;
      wr_valid = (wr_idx < wr_n);
      wr_data  = wr_valid ? wr_src[wr_idx] : 32'h0;
      hs_pend  = wr_valid && wr_ready;
      // read stream sink with an optional stall on one chosen beat
      if (rd_valid) begin
        if (rd_log_n == stall_at && stall_run < stall_cfg) begin
          rd_ready = 1'b0;
          stall_run++;
        end else begin
          rd_ready = 1'b1;
        end
      end else begin
        rd_ready = 1'b0;
      end
      p_hs = rd_valid && rd_ready;
      if (p_hs) begin
        rd_log[rd_log_n] = rd_data;
        rd_log_n++;
        stall_run = 0;
      end
      p_rdv   = rd_valid;
      p_rdata = rd_data;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  int b_done, b_err, b_stb, b_stbr, b_cyc, b_cycr, b_wrr, b_rdv, b_log, b_rdlog;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic snap();
    b_done = done_cnt; b_err = err_cnt; b_stb = stb_cyc; b_stbr = stb_rise;
    b_cyc = cyc_cyc; b_cycr = cyc_rise; b_wrr = wrr_cyc; b_rdv = rdv_cyc;
    b_log = log_n; b_rdlog = rd_log_n;
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [7:0] len);
    @(negedge clk);
    check_val("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_len = 8'h0;
  endtask

  task automatic wait_end(input int max_cyc);
    int base;
    bit seen;
    base = b_done + b_err;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk); #1;
      if (done_cnt + err_cnt != base) seen = 1'b1;
    end
    check_val("end_event_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_len = 8'h0;
    #3;
    check_val("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check_val("rst_stb", 32'(wbm_stb_o), 32'd0);
    check_val("rst_we", 32'(wbm_we_o), 32'd0);
    check_val("rst_sel", 32'(wbm_sel_o), 32'd0);
    check_val("rst_adr", wbm_adr_o, 32'd0);
    check_val("rst_dat_o", wbm_dat_o, 32'd0);
    check_val("rst_rd_data", rd_data, 32'd0);
    check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_val("rst_wr_ready", 32'(wr_ready), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_val("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // T1: write 3 beats, unaligned base, slave acks one cycle after stb
    wr_src[wr_n] = 32'h11; wr_n++;
    wr_src[wr_n] = 32'h22; wr_n++;
    wr_src[wr_n] = 32'h33; wr_n++;
    ack_en = 1'b1; ack_delay = 2;
    exp_q.push_back(32'h3000_0000); exp_q.push_back(32'h11);
    exp_q.push_back(32'h3000_0004); exp_q.push_back(32'h22);
    exp_q.push_back(32'h3000_0008); exp_q.push_back(32'h33);
    snap();
    send_cmd(1'b1, 32'h3000_0003, 8'd3);
    wait_end(100);
    check_val("t1_beats", 32'(log_n - b_log), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("t1_adr%0d", i), log_adr[b_log + i], exp_q.pop_front());
      check_val($sformatf("t1_dat%0d", i), log_dat[b_log + i], exp_q.pop_front());
      check_val($sformatf("t1_sel%0d", i), 32'(log_sel[b_log + i]), 32'hF);
      check_val($sformatf("t1_we%0d", i), 32'(log_we[b_log + i]), 32'd1);
    end
    check_val("t1_stb_rises", 32'(stb_rise - b_stbr), 32'd3);
    check_val("t1_cyc_rises", 32'(cyc_rise - b_cycr), 32'd1);
    check_val("t1_done", 32'(done_cnt - b_done), 32'd1);
    check_val("t1_err", 32'(err_cnt - b_err), 32'd0);

    // T2: read 2 beats, first beat stalled 5 cycles on the read stream
    rd_src[rs_n] = 32'hA5A5_A5A5; rs_n++;
    rd_src[rs_n] = 32'h5A5A_5A5A; rs_n++;
    stall_at = rd_log_n; stall_cfg = 5;
    exp_q.push_back(32'h3000_0010); exp_q.push_back(32'h3000_0014);
    snap();
    send_cmd(1'b0, 32'h3000_0010, 8'd2);
    wait_end(100);
    stall_cfg = 0;
    check_val("t2_adr0", log_adr[b_log], exp_q.pop_front());
    check_val("t2_adr1", log_adr[b_log + 1], exp_q.pop_front());
    check_val("t2_we0", 32'(log_we[b_log]), 32'd0);
    check_val("t2_rd_beats", 32'(rd_log_n - b_rdlog), 32'd2);
    check_val("t2_rd0", rd_log[b_rdlog], 32'hA5A5_A5A5);
    check_val("t2_rd1", rd_log[b_rdlog + 1], 32'h5A5A_5A5A);
    check_val("t2_rdv_cycles", 32'(rdv_cyc - b_rdv), 32'd7);
    check_val("t2_stb_rises", 32'(stb_rise - b_stbr), 32'd2);
    check_val("t2_cyc_rises", 32'(cyc_rise - b_cycr), 32'd1);
    check_val("t2_done", 32'(done_cnt - b_done), 32'd1);
    check_val("t2_err", 32'(err_cnt - b_err), 32'd0);

    // T3: slave never acks, read 2 beats -> abort after 4 strobe cycles
    ack_en = 1'b0;
    snap();
    send_cmd(1'b0, 32'h3000_0020, 8'd2);
    wait_end(100);
    check_val("t3_stb_cycles", 32'(stb_cyc - b_stb), 32'd4);
    check_val("t3_err", 32'(err_cnt - b_err), 32'd1);
    check_val("t3_done", 32'(done_cnt - b_done), 32'd0);
    check_val("t3_rdv_cycles", 32'(rdv_cyc - b_rdv), 32'd0);
    check_val("t3_cmd_ready", 32'(cmd_ready), 32'd1);
    check_val("t3_cyc_idle", 32'(wbm_cyc_o), 32'd0);

    // T4: ack lands on the 4th strobe cycle -> still a success
    ack_en = 1'b1; ack_delay = 4;
    rd_src[rs_n] = 32'h1234_5678; rs_n++;
    snap();
    send_cmd(1'b0, 32'h3000_0030, 8'd1);
    wait_end(100);
    check_val("t4_stb_cycles", 32'(stb_cyc - b_stb), 32'd4);
    check_val("t4_err", 32'(err_cnt - b_err), 32'd0);
    check_val("t4_done", 32'(done_cnt - b_done), 32'd1);
    check_val("t4_rd0", rd_log[b_rdlog], 32'h1234_5678);

    // T5: zero-length write -> no bus or stream activity, single done
    ack_delay = 2;
    snap();
    send_cmd(1'b1, 32'h3000_0040, 8'd0);
    wait_end(20);
    check_val("t5_stb_cycles", 32'(stb_cyc - b_stb), 32'd0);
    check_val("t5_cyc_cycles", 32'(cyc_cyc - b_cyc), 32'd0);
    check_val("t5_wr_ready", 32'(wrr_cyc - b_wrr), 32'd0);
    check_val("t5_done", 32'(done_cnt - b_done), 32'd1);

    // T6: address wrap at the top of the 32-bit space
    rd_src[rs_n] = 32'hCAFE_0001; rs_n++;
    rd_src[rs_n] = 32'hCAFE_0002; rs_n++;
    snap();
    send_cmd(1'b0, 32'hFFFF_FFFC, 8'd2);
    wait_end(100);
    check_val("t6_adr0", log_adr[b_log], 32'hFFFF_FFFC);
    check_val("t6_adr1", log_adr[b_log + 1], 32'h0000_0000);
    check_val("t6_rd1", rd_log[b_rdlog + 1], 32'hCAFE_0002);
    check_val("t6_done", 32'(done_cnt - b_done), 32'd1);

    // T7: asynchronous reset while strobing, then a normal write
    ack_en = 1'b0;
    snap();
    send_cmd(1'b0, 32'h3000_0050, 8'd1);
    @(negedge clk); #1;
    check_val("t7_stb_before_rst", 32'(wbm_stb_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t7_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check_val("t7_rst_stb", 32'(wbm_stb_o), 32'd0);
    check_val("t7_rst_rd_valid", 32'(rd_valid), 32'd0);
    check_val("t7_rst_done", 32'(done), 32'd0);
    check_val("t7_rst_err", 32'(err), 32'd0);
    check_val("t7_rst_adr", wbm_adr_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1; ack_delay = 2;
    wr_src[wr_n] = 32'hCAFE_F00D; wr_n++;
    snap();
    send_cmd(1'b1, 32'h3000_0100, 8'd1);
    wait_end(100);
    check_val("t7_adr", log_adr[b_log], 32'h3000_0100);
    check_val("t7_dat", log_dat[b_log], 32'hCAFE_F00D);
    check_val("t7_done", 32'(done_cnt - b_done), 32'd1);
    check_val("t7_err", 32'(err_cnt - b_err), 32'd0);

    // Whole-run protocol invariants
    check_val("rd_data_stable", 32'(rd_unstable), 32'd0);
    check_val("no_stb_during_hold", 32'(stb_in_hold), 32'd0);
    check_val("no_cmd_ready_busy", 32'(busy_ready), 32'd0);
    check_val("err_with_bus_idle", 32'(err_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_master_seq.md
Name: wb_master_seq

Overview:
- Wishbone classic-cycle initiator.
- Takes one command (direction, base address, word count), then issues that many single-word bus cycles at consecutive word addresses.
- Write data comes from a valid/ready stream; read data goes to a valid/ready stream.
- Drives the user-area Wishbone slave port (wbs_*) of the Caravel user project from a testbench-side or firmware-offload master. It is the initiator end of that bus.

Parameters:
- LEN_W, 8: width of the command word count (max 2^LEN_W-1 beats).
- TIMEOUT, 255: cycles with stb high and no ack before the command aborts (must be ≥1).

Ports:
- wb_clk_i  in  1  single clock, all logic rising-edge.
- wb_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_we  in  1  1=write, 0=read.
- cmd_adr  in  32  byte base address; bits [1:0] ignored and forced 0.
- cmd_len  in  LEN_W  number of beats.
- wr_data  in  32  write stream data.
- wr_valid  in  1  write stream valid.
- wr_ready  out  1  write stream ready.
- rd_data  out  32  read stream data.
- rd_valid  out  1  read stream valid.
- rd_ready  in  1  read stream ready.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte selects; always 4'hF during stb.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- done  out  1  one-cycle pulse, command completed normally.
- err  out  1  one-cycle pulse, command aborted on timeout.

Behaviour:
- Reset (async assert, sync release): state=IDLE; cmd_ready=1 once out of reset; all other outputs 0, including wbm_adr_o and rd_data.
- Command acceptance: cmd_valid&cmd_ready latches we, adr&~3, len; beat counter is cleared.
  - len=0: go to DONE, no bus activity; done pulses the following cycle.
- States: IDLE, FETCH, BUS, HOLD, DONE.
- IDLE -> FETCH (write) or BUS (read) on accept.
- FETCH (write only): wr_ready=1.
  - On wr_valid, latch wr_data into wbm_dat_o and go to BUS.
  - No timeout while in FETCH.
- BUS:
  - wbm_cyc_o=1, wbm_stb_o=1, wbm_we_o=latched we, wbm_adr_o=base+4*beat.
  - Timeout counter increments each BUS cycle without ack.
  - On wbm_ack_i (read): capture wbm_dat_i into rd_data, set rd_valid, go to HOLD.
  - On wbm_ack_i (write): beat++; next state is FETCH if beats remain, else DONE.
  - stb drops the cycle after ack (no back-to-back strobes, classic cycle).
  - wbm_cyc_o stays 1 from the first BUS entry until the last ack or an abort, including FETCH/HOLD gaps between beats.
  - ack is ignored whenever stb=0.
- HOLD (read): rd_valid=1 and rd_data stable until rd_ready.
  - On the rd_valid&rd_ready handshake: beat++; next state is BUS if beats remain, else DONE.
- Timeout: the counter reaches TIMEOUT in BUS with no ack. Then:
  - cyc and stb drop the next cycle;
  - err pulses for 1 cycle;
  - go to IDLE; done is not pulsed;
  - remaining beats are discarded; no further wr_ready or rd_valid for this command.
  - The counter clears on every ack and on BUS entry.
- Ack on the same cycle the counter reaches TIMEOUT counts as success; no err.
- DONE: done=1 for exactly one cycle, cyc=0, then IDLE.
- Address arithmetic: 32-bit wrap, so 0xFFFFFFFC+4 → 0x00000000. No error on wrap.
- Reset mid-command: all outputs return to reset values immediately (asynchronous). The in-flight beat is lost.
- A cmd_valid arriving while busy is held off (cmd_ready=0). It is not queued.

Test Plan:
- Write len=3, adr=0x30000003, wr_data 0x11,0x22,0x33; slave acks 1 cycle after stb -> bus writes to 0x30000000/04/08 with those data, sel=F, cyc continuous, one done pulse, err=0.
- Read len=2, adr=0x30000010, slave returns 0xA5A5A5A5 then 0x5A5A5A5A; rd_ready held low 5 cycles on beat 0 -> rd_data stable through the stall, second stb only after the handshake, done after beat 1 delivered.
- Slave never acks, TIMEOUT=4, read len=2 -> stb high exactly 4 cycles, cyc/stb low next cycle, err pulse, no done, no rd_valid, cmd_ready=1 after.
- Ack arrives on cycle 4 with TIMEOUT=4 -> beat completes, no err.
- len=0 write -> no cyc/stb/wr_ready ever asserted; done pulses once.
- Address wrap: read len=2 at 0xFFFFFFFC -> addresses 0xFFFFFFFC then 0x00000000.
- wb_rst_n low mid-BUS -> cyc/stb/rd_valid/done/err go to 0 without a clock edge. Next command runs normally.
